// File: rtl/wb_stage.sv
// Write-back data select and register for the unpipelined RV32I core.
// Optional macro WB_SLT_EN enables lt/ltu selection via wos for OP/OP-IMM.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] read_data,
    input  logic [31:0] result,
    input  logic [6:0]  opcode,
    input  logic [31:0] PC_4,
    input  logic        su,
    input  logic [1:0]  whb,
    input  logic [1:0]  wos,
    input  logic        lt,
    input  logic        ltu,
    output logic [31:0] DataOut_WB
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    function automatic logic [31:0] load_ext(input logic [31:0] d,
                                             input logic [1:0]  w,
                                             input logic        s);
        logic signed [31:0] ext;
        ext = d;
        case (w)
            2'b00:   ext = s ? 32'(signed'(d[7:0]))  : {24'b0, d[7:0]};
            2'b01:   ext = s ? 32'(signed'(d[15:0])) : {16'b0, d[15:0]};
            default: ext = d;
        endcase
        return ext;
    endfunction

    function automatic logic [31:0] alu_sel(input logic [31:0] r,
                                            input logic [1:0]  w,
                                            input logic        f_lt,
                                            input logic        f_ltu);
        logic [31:0] v;
        v = r;
`ifdef WB_SLT_EN
        case (w)
            2'b01:   v = {31'b0, f_lt};
            2'b10:   v = {31'b0, f_ltu};
            default: v = r;
        endcase
`else
        v = r;
`endif
        return v;
    endfunction

`ifndef WB_SLT_EN
    // Flags and wos stay on the port list but have no consumer in this build.
    logic unused_slt;
    assign unused_slt = ^{wos, lt, ltu};
`endif

    logic [31:0] wb_data_p0;

    always_comb begin
        wb_data_p0 = 32'h0000_0000;
        case (opcode)
            OPC_LOAD:            wb_data_p0 = load_ext(read_data, whb, su);
            OPC_OPIMM, OPC_OP:   wb_data_p0 = alu_sel(result, wos, lt, ltu);
            OPC_JAL, OPC_JALR:   wb_data_p0 = PC_4;
            OPC_LUI, OPC_AUIPC:  wb_data_p0 = result;
            default:             wb_data_p0 = 32'h0000_0000;
        endcase
    end

    // p0 -> output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DataOut_WB <= 32'h0000_0000;
        end else begin
            DataOut_WB <= wb_data_p0;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases from the test plan plus
// randomized traffic checked against a behavioural write-back model.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic [31:0] read_data;
    logic [31:0] result;
    logic [6:0]  opcode;
    logic [31:0] PC_4;
    logic        su;
    logic [1:0]  whb;
    logic [1:0]  wos;
    logic        lt;
    logic        ltu;
    logic [31:0] DataOut_WB;

    int total = 0;
    int bad   = 0;

    wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .read_data  (read_data),
        .result     (result),
        .opcode     (opcode),
        .PC_4       (PC_4),
        .su         (su),
        .whb        (whb),
        .wos        (wos),
        .lt         (lt),
        .ltu        (ltu),
        .DataOut_WB (DataOut_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: written from the instruction-class rules using integer arithmetic.
    function automatic logic [31:0] model(input logic [6:0] op, input logic [31:0] rd,
                                          input logic [31:0] res, input logic [31:0] pc,
                                          input logic s, input logic [1:0] w,
                                          input logic [1:0] sel, input logic f_lt,
                                          input logic f_ltu);
        int unsigned b, h;
        b = rd % 256;
        h = rd % 65536;
        if (op == 7'b0000011) begin
            if (w == 2'd0) return (s && b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            if (w == 2'd1) return (s && h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            return rd;
        end
        if (op == 7'b0010011 || op == 7'b0110011) begin
`ifdef WB_SLT_EN
            if (sel == 2'd1) return f_lt ? 32'd1 : 32'd0;
            if (sel == 2'd2) return f_ltu ? 32'd1 : 32'd0;
`endif
            return res;
        end
        if (op == 7'b1101111 || op == 7'b1100111) return pc;
        if (op == 7'b0110111 || op == 7'b0010111) return res;
        return 32'd0;
    endfunction

    task automatic drive(input logic [6:0] op, input logic [31:0] rd, input logic [31:0] res,
                         input logic [31:0] pc, input logic s, input logic [1:0] w,
                         input logic [1:0] sel, input logic f_lt, input logic f_ltu);
        opcode = op; read_data = rd; result = res; PC_4 = pc;
        su = s; whb = w; wos = sel; lt = f_lt; ltu = f_ltu;
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input string tag, input logic [31:0] exp,
                        input logic [6:0] op, input logic [31:0] rd, input logic [31:0] res,
                        input logic [31:0] pc, input logic s, input logic [1:0] w,
                        input logic [1:0] sel, input logic f_lt, input logic f_ltu);
        @(negedge clk);
        drive(op, rd, res, pc, s, w, sel, f_lt, f_ltu);
        @(posedge clk);
        #1;
        check(tag, DataOut_WB, exp);
    endtask

    logic [6:0]  ops [10];
    logic [31:0] slt_lt_exp, slt_ltu_exp;

    initial begin
        ops = '{7'b0000011, 7'b0010011, 7'b0110011, 7'b1101111, 7'b1100111,
                7'b0110111, 7'b0010111, 7'b0100011, 7'b1100011, 7'b1110011};
`ifdef WB_SLT_EN
        slt_lt_exp  = 32'd0;
        slt_ltu_exp = 32'd1;
`else
        slt_lt_exp  = 32'd200;
        slt_ltu_exp = 32'd200;
`endif
        rst = 1'b0;
        drive(7'b0010011, $urandom, $urandom, $urandom, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
        #1 rst = 1'b1;
        #2;
        check("rst_async", DataOut_WB, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold", DataOut_WB, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        step("opimm_200", 32'd200, 7'b0010011, 32'h0, 32'd200, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        step("slt_lt",  slt_lt_exp,  7'b0010011, 32'h0, 32'd200, 32'h0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1);
        step("slt_ltu", slt_ltu_exp, 7'b0010011, 32'h0, 32'd200, 32'h0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1);
        step("slt_res", 32'd200,     7'b0010011, 32'h0, 32'd200, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        step("lb_100",  32'd100,       7'b0000011, 32'd100,      32'h0, 32'h0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
        step("lb_sx",   32'hFFFF_FFF0, 7'b0000011, 32'h0000_00F0, 32'h0, 32'h0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
        step("lb_zx",   32'h0000_00F0, 7'b0000011, 32'h0000_00F0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        step("lh_sx",   32'hFFFF_8001, 7'b0000011, 32'h1234_8001, 32'h0, 32'h0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
        step("lh_zx",   32'h0000_8001, 7'b0000011, 32'h1234_8001, 32'h0, 32'h0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
        step("lw",      32'h1234_8001, 7'b0000011, 32'h1234_8001, 32'h0, 32'h0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0);
        step("lw_11",   32'h1234_8001, 7'b0000011, 32'h1234_8001, 32'h0, 32'h0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
        step("jal",     32'd8,         7'b1101111, 32'h5, 32'h7, 32'd8, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        step("store",   32'h0,         7'b0100011, 32'h5, 32'h7, 32'd8, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        step("lui",     32'hABCD_E000, 7'b0110111, 32'h5, 32'hABCD_E000, 32'd8, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        // Async reset in the middle of operation.
        step("pre_rst", 32'd200, 7'b0110011, 32'h0, 32'd200, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_async", DataOut_WB, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_mid_hold", DataOut_WB, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 32'd200, 7'b0110011, 32'h0, 32'd200, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [6:0]  op;
            logic [31:0] rd, res, pc;
            logic        s, fl, fu;
            logic [1:0]  w, sel;
            int          k;
            k = $urandom_range(0, 10);
            op  = (k == 10) ? 7'($urandom) : ops[k];
            rd  = $urandom; res = $urandom; pc = $urandom;
            s   = 1'($urandom); fl = 1'($urandom); fu = 1'($urandom);
            w   = 2'($urandom); sel = 2'($urandom);
            step("rand", model(op, rd, res, pc, s, w, sel, fl, fu),
                 op, rd, res, pc, s, w, sel, fl, fu);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
